// File: rtl/lane_rr_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick helper for lane_rr_arbiter.
package lane_arb_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_ID_W   = 2;
  // Widest supported requester set; the helper works on vectors padded to this size.
  localparam int unsigned N_MAX      = 8;
  localparam int unsigned ID_MAX     = 3;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Search starts one past ptr and wraps modulo n; returns {found, index}.
  function automatic logic [ID_MAX:0] rr_pick(input logic [N_MAX-1:0]  valid,
                                              input logic [ID_MAX-1:0] ptr,
                                              input int unsigned       n);
    logic              found;
    logic [ID_MAX-1:0] idx;
    int                cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= int'(N_MAX); i++) begin
      cand = (int'(ptr) + i) % int'(n);
      if ((i <= int'(n)) && !found && valid[ID_MAX'(cand)]) begin
        found = 1'b1;
        idx   = ID_MAX'(cand);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/lane_rr_arbiter_if.sv
// Lane-side and output-side handshake bundle for lane_rr_arbiter.
// With LANE_ARB_LOCK_EN defined the bundle also carries in_last/out_last.
interface lane_rr_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 2
);

  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        in_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [ID_W-1:0]         out_id;
  logic                    out_ready;
`ifdef LANE_ARB_LOCK_EN
  logic [N_REQ-1:0]        in_last;
  logic                    out_last;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_id, out_last);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_id, out_last);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_id);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_id);
`endif

endinterface

// File: rtl/lane_rr_arbiter_rr_pick_comb.sv
// Combinational rotate-and-priority-encode: first valid lane after i_ptr.
module rr_pick_comb
  import lane_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned ID_W  = DEF_ID_W
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_found_c,
  output logic [ID_W-1:0]  o_idx_c
);

  logic [ID_MAX:0] w_pick;

  // Pad to the helper's fixed width and split {found, index}.
  always_comb begin
    w_pick    = rr_pick(N_MAX'(i_valid), ID_MAX'(i_ptr), N_REQ);
    o_found_c = w_pick[ID_MAX];
    o_idx_c   = ID_W'(w_pick[ID_MAX-1:0]);
  end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter forwarding one lane's byte per beat into a registered output.
// Optional macro LANE_ARB_LOCK_EN: grant stays on a lane until its in_last beat.
module lane_rr_arbiter
  import lane_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned ID_W   = DEF_ID_W
) (
  input  logic              clkf,
  input  logic              reset,
  lane_rr_arbiter_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ID_W-1:0]   r_out_id;
`ifdef LANE_ARB_LOCK_EN
  logic              r_out_last;
`endif

  logic              w_can_load;
  logic              w_pick_found;
  logic [ID_W-1:0]   w_pick_idx;
  logic              w_grant_found;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_xfer;
  logic [N_REQ-1:0]  w_in_ready;

  rr_pick_comb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_valid   (bus.in_valid),
    .i_ptr     (r_rr_ptr),
    .o_found_c (w_pick_found),
    .o_idx_c   (w_pick_idx)
  );

  // State register; the lock lane is always r_rr_ptr since every transfer updates it.
  always_ff @(posedge clkf) begin
    if (reset) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant selection, lane ready and next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_found = 1'b0;
    w_grant_idx   = w_pick_idx;
    w_in_ready    = '0;
    w_can_load    = !r_out_valid || bus.out_ready;

    case (r_state)
      ST_ARB: begin
        w_grant_found = w_pick_found;
        w_grant_idx   = w_pick_idx;
      end
`ifdef LANE_ARB_LOCK_EN
      ST_LOCK: begin
        w_grant_found = bus.in_valid[r_rr_ptr];
        w_grant_idx   = r_rr_ptr;
      end
`endif
      default: begin
        w_grant_found = 1'b0;
      end
    endcase

    w_xfer = w_grant_found && w_can_load && !reset;
    if (w_xfer) begin
      w_in_ready[w_grant_idx] = 1'b1;
    end

`ifdef LANE_ARB_LOCK_EN
    if (w_xfer) begin
      if (r_state == ST_ARB && !bus.in_last[w_grant_idx]) begin
        w_state_nxt = ST_LOCK;
      end else if (r_state == ST_LOCK && bus.in_last[w_grant_idx]) begin
        w_state_nxt = ST_ARB;
      end
    end
`endif
  end

  // Output beat register and round-robin pointer; a new load replaces a draining beat.
  always_ff @(posedge clkf) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= ID_W'(N_REQ - 1);
`ifdef LANE_ARB_LOCK_EN
      r_out_last  <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data[w_grant_idx*DATA_W +: DATA_W];
      r_out_id    <= w_grant_idx;
      r_rr_ptr    <= w_grant_idx;
`ifdef LANE_ARB_LOCK_EN
      r_out_last  <= bus.in_last[w_grant_idx];
`endif
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
`ifdef LANE_ARB_LOCK_EN
  assign bus.out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Self-checking bench for lane_rr_arbiter: directed vectors plus a per-cycle reference model.
module tb_lane_rr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clkf;
  logic reset;
  int   checks;
  int   failures;
  bit   chk_en;

  lane_rr_arbiter_if #(.DATA_W(DW), .N_REQ(N), .ID_W(IW)) bus ();

  lane_rr_arbiter #(.DATA_W(DW), .N_REQ(N), .ID_W(IW)) dut (
    .clkf  (clkf),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clkf = 1'b0;
  always #5 clkf = ~clkf;

  // Reference model: state of the output beat, last granted lane and lock flag.
  bit        m_valid;
  int        m_data;
  int        m_id;
  int        m_ptr;
  bit        m_lock;
  bit        m_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Which lane the rules say is accepted this cycle, if any.
  function automatic void m_grant(output bit found, output int g);
    found = 1'b0;
    g     = 0;
    if (reset) return;
    if (m_valid && !bus.out_ready) return;
    if (m_lock) begin
      if (bus.in_valid[m_ptr]) begin
        found = 1'b1;
        g     = m_ptr;
      end
      return;
    end
    for (int k = 1; k <= N; k++) begin
      int lane;
      lane = (m_ptr + k) % N;
      if (!found && bus.in_valid[lane]) begin
        found = 1'b1;
        g     = lane;
      end
    end
  endfunction

  always @(posedge clkf) begin
    bit f;
    int g;
    m_grant(f, g);
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_id    = 0;
      m_ptr   = N - 1;
      m_lock  = 1'b0;
      m_last  = 1'b0;
    end else if (f) begin
      m_valid = 1'b1;
      m_data  = int'(bus.in_data[g*DW +: DW]);
      m_id    = g;
      m_ptr   = g;
`ifdef LANE_ARB_LOCK_EN
      m_last  = bus.in_last[g];
      if (m_lock) begin
        if (bus.in_last[g]) m_lock = 1'b0;
      end else if (!bus.in_last[g]) begin
        m_lock = 1'b1;
      end
`endif
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clkf) begin
    if (chk_en) begin
      bit f;
      int g;
      int exp_rdy;
      m_grant(f, g);
      exp_rdy = f ? (1 << g) : 0;
      chk("model_in_ready",  int'(bus.in_ready),  exp_rdy);
      chk("model_out_valid", int'(bus.out_valid), int'(m_valid));
      chk("model_out_data",  int'(bus.out_data),  m_data);
      chk("model_out_id",    int'(bus.out_id),    m_id);
`ifdef LANE_ARB_LOCK_EN
      chk("model_out_last",  int'(bus.out_last),  int'(m_last));
`endif
    end
  end

  task automatic tick();
    @(posedge clkf);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [N-1:0] tv_valid [16];
  logic         tv_ready [16];

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.out_ready = 1'b1;
`ifdef LANE_ARB_LOCK_EN
    bus.in_last   = 4'hF;
`endif

    // Reset held 3 cycles with every lane requesting.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_en = 1'b1;
      chk("rst_in_ready",  int'(bus.in_ready),  0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_id",    int'(bus.out_id),    0);
    end

    // Rotation with all lanes valid.
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rot_valid", int'(bus.out_valid), 1);
      chk("rot_id",    int'(bus.out_id),    c % N);
      chk("rot_data",  int'(bus.out_data),  8'hA0 + (c % N));
    end

    // Backpressure holds the first beat and blocks all lanes.
    do_reset();
    bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    chk("bp_first_id",   int'(bus.out_id),   0);
    chk("bp_first_data", int'(bus.out_data), 8'h11);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", int'(bus.out_valid), 1);
      chk("bp_hold_data",  int'(bus.out_data),  8'h11);
      chk("bp_hold_rdy",   int'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_id",   int'(bus.out_id),   1);
    chk("bp_release_data", int'(bus.out_data), 8'h22);

    // Sparse requests and wrap from pointer 3.
    do_reset();
    bus.in_valid = 4'b0100;
    tick();
    chk("sparse_id2", int'(bus.out_id), 2);
    bus.in_valid = 4'b1100;
    tick();
    chk("wrap_id3", int'(bus.out_id), 3);
    tick();
    chk("wrap_id2", int'(bus.out_id), 2);

    // Reset while a beat is pending discards it and restarts the rotation.
    do_reset();
    bus.in_valid = 4'hF;
    tick();
    tick();
    chk("midrst_pre_id", int'(bus.out_id), 1);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_id",    int'(bus.out_id),    0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("midrst_next_id", int'(bus.out_id), 0);

`ifdef LANE_ARB_LOCK_EN
    // Lane 1 locks the path for a three-beat packet while lane 0 waits.
    do_reset();
    bus.in_valid = 4'b0010;
    bus.in_last  = 4'b0000;
    tick();
    chk("lock_b1", int'(bus.out_id), 1);
    bus.in_valid = 4'b0011;
    #1;
    chk("lock_rdy_a", int'(bus.in_ready), 4'b0010);
    tick();
    chk("lock_b2", int'(bus.out_id), 1);
    bus.in_last = 4'b0011;
    #1;
    chk("lock_rdy_b", int'(bus.in_ready), 4'b0010);
    tick();
    chk("lock_b3",   int'(bus.out_id),   1);
    chk("lock_last", int'(bus.out_last), 1);
    tick();
    chk("lock_after", int'(bus.out_id), 0);
    bus.in_last = 4'hF;
`endif

    // Mixed request/ready vectors, checked by the model each cycle.
    tv_valid = '{4'h5, 4'h0, 4'hA, 4'hF, 4'h8, 4'h1, 4'h3, 4'hC,
                 4'hF, 4'h0, 4'h6, 4'h9, 4'hF, 4'h2, 4'h4, 4'hF};
    tv_ready = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid  = tv_valid[i];
      bus.out_ready = tv_ready[i];
      bus.in_data   = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
`ifdef LANE_ARB_LOCK_EN
      bus.in_last   = (i % 3 == 0) ? 4'h0 : 4'hF;
`endif
      tick();
    end

    bus.in_valid = '0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
